lfsr_priority_arbiter: RTL and testbench

Parametrised successor to the fixed 16-bit Galois random-priority selector in the MemorEDF queue front-end. It chooses one non-empty queue out of `NUMBER_OF_QUEUES` using either a rotating-priority scan seeded by a configurable Galois LFSR or a round-robin pointer. The decision goes out through a registered valid/ready grant port so the downstream dequeue path can stall it. It sits between the per-queue FIFOs' `empty` flags and the queue-pop/mux logic.

---
 rtl/lfsr_priority_arbiter.sv | 115 +++++++++++
 tb/tb_lfsr_priority_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_priority_arbiter.sv
// Picks one non-empty queue per decision, starting either at an LFSR-derived
// offset or one past the last accepted grant, and presents it on a valid/ready port.
module lfsr_priority_arbiter #(
    parameter int                     STATE_WIDTH      = 16,
    parameter logic [STATE_WIDTH-1:0] TAPS             = 16'hB400,
    parameter logic [STATE_WIDTH-1:0] SEED             = 16'h8000,
    parameter int                     NUMBER_OF_QUEUES = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUMBER_OF_QUEUES-1:0]         empty,
    input  logic                                mode,
    input  logic                                seed_load,
    input  logic [STATE_WIDTH-1:0]              seed_value,
    output logic                                any_valid,
    output logic                                grant_valid,
    input  logic                                grant_ready,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0] grant_index
);

    localparam int IDX_W = $clog2(NUMBER_OF_QUEUES);
    localparam logic [IDX_W:0] NQ = (IDX_W + 1)'(NUMBER_OF_QUEUES);
    // The MSB is always fed back from state[0], whether or not TAPS names it.
    localparam logic [STATE_WIDTH-1:0] TAPS_EFF = TAPS | {1'b1, {(STATE_WIDTH - 1){1'b0}}};

    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic                   grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]       grant_index_q, grant_index_d;

    logic             accept;
    logic             load;
    logic [IDX_W-1:0] last_eff;
    logic [IDX_W:0]   r_wide;
    logic [IDX_W:0]   lfsr_off;
    logic [IDX_W:0]   rr_next;
    logic [IDX_W:0]   rr_off;
    logic [IDX_W:0]   offset;
    logic [IDX_W:0]   scan_idx;
    logic             found;
    logic [IDX_W-1:0] candidate;

    assign any_valid   = |(~empty);
    assign grant_valid = grant_valid_q;
    assign grant_index = grant_index_q;

    always_comb begin
        state_d = (state_q >> 1) ^ (state_q[0] ? TAPS_EFF : '0);
        if (seed_load) begin
            state_d = (seed_value == '0) ? SEED : seed_value;
        end
    end

    always_comb begin
        accept = grant_valid_q & grant_ready;
        load   = ~grant_valid_q | grant_ready;

        r_wide   = {1'b0, state_q[IDX_W-1:0]};
        lfsr_off = (r_wide >= NQ) ? (r_wide - NQ) : r_wide;

        // A grant accepted this cycle must steer the decision loading alongside
        // it, otherwise back-to-back round-robin would repeat the same queue.
        last_eff = accept ? grant_index_q : last_q;
        rr_next  = {1'b0, last_eff} + (IDX_W + 1)'(1);
        rr_off   = (rr_next == NQ) ? '0 : rr_next;

        offset = mode ? rr_off : lfsr_off;
    end

    always_comb begin
        found     = 1'b0;
        candidate = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            scan_idx = offset + (IDX_W + 1)'(i);
            if (scan_idx >= NQ) begin
                scan_idx = scan_idx - NQ;
            end
            if (!found && !empty[scan_idx[IDX_W-1:0]]) begin
                found     = 1'b1;
                candidate = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        last_d        = last_q;
        grant_valid_d = grant_valid_q;
        grant_index_d = grant_index_q;
        if (accept) begin
            last_d = grant_index_q;
        end
        if (load) begin
            grant_valid_d = any_valid;
            if (any_valid) begin
                grant_index_d = candidate;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= SEED;
            last_q        <= IDX_W'(NUMBER_OF_QUEUES - 1);
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            grant_valid_q <= grant_valid_d;
            grant_index_q <= grant_index_d;
        end
    end

endmodule

// File: tb/tb_lfsr_priority_arbiter.sv
// Directed bench for lfsr_priority_arbiter: default 4-queue build plus a
// 3-queue / 8-bit LFSR build, checked against a queue of expected grants.
module tb_lfsr_priority_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  empty;
    logic        mode;
    logic        seed_load;
    logic [15:0] seed_value;
    logic        any_valid;
    logic        grant_valid;
    logic        grant_ready;
    logic [1:0]  grant_index;

    logic        reset3;
    logic [2:0]  empty3;
    logic        mode3;
    logic        seed_load3;
    logic [7:0]  seed_value3;
    logic        any_valid3;
    logic        grant_valid3;
    logic        grant_ready3;
    logic [1:0]  grant_index3;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    logic [15:0] m_state;
    logic [7:0]  m3_state;
    int seen[3];

    always #5 clock = ~clock;

    lfsr_priority_arbiter u_dut (
        .clock       (clock),
        .reset       (reset),
        .empty       (empty),
        .mode        (mode),
        .seed_load   (seed_load),
        .seed_value  (seed_value),
        .any_valid   (any_valid),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_index (grant_index)
    );

    lfsr_priority_arbiter #(
        .STATE_WIDTH      (8),
        .TAPS             (8'hB8),
        .SEED             (8'h03),
        .NUMBER_OF_QUEUES (3)
    ) u_dut3 (
        .clock       (clock),
        .reset       (reset3),
        .empty       (empty3),
        .mode        (mode3),
        .seed_load   (seed_load3),
        .seed_value  (seed_value3),
        .any_valid   (any_valid3),
        .grant_valid (grant_valid3),
        .grant_ready (grant_ready3),
        .grant_index (grant_index3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        int e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, 32'(e));
        end
    endtask

    // Advance one clock; bench LFSR models follow the documented update rule.
    task automatic step();
        logic [15:0] n;
        logic [7:0]  n3;
        if (reset)          n = 16'h8000;
        else if (seed_load) n = (seed_value == 16'h0) ? 16'h8000 : seed_value;
        else                n = (m_state >> 1) ^ (m_state[0] ? 16'hB400 : 16'h0000);
        if (reset3)         n3 = 8'h03;
        else                n3 = (m3_state >> 1) ^ (m3_state[0] ? 8'hB8 : 8'h00);
        @(posedge clock);
        #1;
        m_state  = n;
        m3_state = n3;
    endtask

    initial begin
        reset = 1'b1; empty = 4'b0000; mode = 1'b0; grant_ready = 1'b1;
        seed_load = 1'b0; seed_value = 16'h0000;
        reset3 = 1'b1; empty3 = 3'b000; mode3 = 1'b0; grant_ready3 = 1'b1;
        seed_load3 = 1'b0; seed_value3 = 8'h00;
        m_state = 16'h8000; m3_state = 8'h03;
        seen[0] = 0; seen[1] = 0; seen[2] = 0;

        // Reset state
        step(); step();
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_index", 32'(grant_index), 32'd0);
        chk("rst_state", 32'(u_dut.state_q), 32'h8000);
        chk("any_valid_full", 32'(any_valid), 32'd1);

        // LFSR mode, all queues ready: 0 x14, then 2, 1, 0
        reset = 1'b0;
        for (int i = 0; i < 14; i++) exp_q.push_back(0);
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
        for (int i = 0; i < 17; i++) begin
            step();
            chk("lfsr_state", 32'(u_dut.state_q), 32'(m_state));
            chk("lfsr_valid", 32'(grant_valid), 32'd1);
            pop_chk("lfsr_grant", 32'(grant_index));
        end
        chk("lfsr_wrap_state", 32'(u_dut.state_q), 32'h5A00);

        // Round-robin
        reset = 1'b1; mode = 1'b1;
        step();
        reset = 1'b0;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int i = 0; i < 5; i++) begin
            step();
            pop_chk("rr_grant", 32'(grant_index));
        end
        empty = 4'b0101;
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(3);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_sparse_valid", 32'(grant_valid), 32'd1);
            pop_chk("rr_sparse_grant", 32'(grant_index));
        end

        // Backpressure: held grant survives empty changes and LFSR motion
        reset = 1'b1; mode = 1'b0; empty = 4'b0000; grant_ready = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("bp_first_valid", 32'(grant_valid), 32'd1);
        chk("bp_first_index", 32'(grant_index), 32'd0);
        for (int i = 0; i < 5; i++) begin
            empty = (i % 2 == 0) ? 4'b0001 : 4'b1110;
            step();
            chk("bp_hold_index", 32'(grant_index), 32'd0);
            chk("bp_hold_valid", 32'(grant_valid), 32'd1);
        end
        chk("bp_state", 32'(u_dut.state_q), 32'h0200);
        grant_ready = 1'b1; empty = 4'b0011;
        step();
        chk("bp_next_index", 32'(grant_index), 32'd2);
        chk("bp_next_valid", 32'(grant_valid), 32'd1);
        grant_ready = 1'b0; empty = 4'b0000;
        step();
        chk("bp_accept_once", 32'(grant_index), 32'd2);

        // Seeding and all-empty
        reset = 1'b1; grant_ready = 1'b1;
        step();
        reset = 1'b0; seed_load = 1'b1; seed_value = 16'h0000;
        step();
        chk("seed_zero", 32'(u_dut.state_q), 32'h8000);
        seed_value = 16'h0003;
        step();
        chk("seed_load", 32'(u_dut.state_q), 32'h0003);
        chk("seed_old_grant", 32'(grant_index), 32'd0);
        seed_load = 1'b0;
        step();
        chk("seed_advance", 32'(u_dut.state_q), 32'hB401);
        chk("seed_first_grant", 32'(grant_index), 32'd3);
        empty = 4'b1111;
        #1;
        chk("any_valid_empty", 32'(any_valid), 32'd0);
        step();
        chk("empty_valid", 32'(grant_valid), 32'd0);
        chk("empty_index_hold", 32'(grant_index), 32'd3);
        step();
        chk("empty_valid_stays", 32'(grant_valid), 32'd0);

        // Three queues, 8-bit LFSR
        step();
        chk("n3_rst_valid", 32'(grant_valid3), 32'd0);
        reset3 = 1'b0;
        step();
        chk("n3_r3_offset", 32'(grant_index3), 32'd0);
        chk("n3_any_valid", 32'(any_valid3), 32'd1);
        for (int i = 0; i < 255; i++) begin
            int r;
            r = int'(m3_state[1:0]);
            exp_q.push_back((r >= 3) ? r - 3 : r);
            step();
            chk("n3_range", 32'(grant_index3 < 2'd3), 32'd1);
            pop_chk("n3_grant", 32'(grant_index3));
            if (grant_index3 < 2'd3) seen[grant_index3]++;
        end
        for (int q = 0; q < 3; q++) begin
            chk("n3_seen", 32'(seen[q] > 0), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
